// File: rtl/vga_scan_pkg.sv
// Shared timing helpers and colour types for the VGA raster scan generator.
package vga_scan_pkg;

  localparam int unsigned PosW   = 14;
  localparam int unsigned VcntW  = 24;
  localparam int unsigned DivW   = 4;
  localparam int unsigned ChanW  = 4;
  localparam int unsigned ColorW = 3 * ChanW;

  // RGB444 field layout: {R[11:8], G[7:4], B[3:0]}
  typedef struct packed {
    logic [ChanW-1:0] r;
    logic [ChanW-1:0] g;
    logic [ChanW-1:0] b;
  } rgb444_t;

  function automatic int unsigned scan_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // First position inside the sync pulse
  function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  // First position past the sync pulse
  function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Pixel clock-enable divider: pix_en is a one-CLK strobe every PIX_DIV cycles.
module pix_ce_div
  import vga_scan_pkg::*;
#(
  parameter int unsigned PIX_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic pix_en
);

  localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  assign pix_en = (div_q == DivLast);

  always_comb begin
    div_d = div_q + DivW'(1);
    if (pix_en) div_d = '0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: active-area coordinates for the cell lookup, and
// registered RGB/sync outputs aligned to the lookup's one-cycle latency.
module vga_scan_gen
  import vga_scan_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 48,
  parameter int unsigned H_BP     = 56,
  parameter int unsigned V_ACTIVE = 270,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 22,
  parameter int unsigned PIX_DIV  = 4,
  parameter rgb444_t     FG_COLOR = 12'hFFF,
  parameter rgb444_t     BG_COLOR = 12'h000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              on,
  output logic [PosW-1:0]   hcnt,
  output logic [VcntW-1:0]  vcnt,
  output logic              de,
  output logic              frame_start,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic [ColorW-1:0] rgb
);

  localparam int unsigned HTotal = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [PosW-1:0] HLast = PosW'(HTotal - 1);
  localparam logic [PosW-1:0] VLast = PosW'(VTotal - 1);
  localparam logic [PosW-1:0] HAct  = PosW'(H_ACTIVE);
  localparam logic [PosW-1:0] VAct  = PosW'(V_ACTIVE);
  localparam logic [PosW-1:0] HsLo  = PosW'(sync_start(H_ACTIVE, H_FP));
  localparam logic [PosW-1:0] HsHi  = PosW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [PosW-1:0] VsLo  = PosW'(sync_start(V_ACTIVE, V_FP));
  localparam logic [PosW-1:0] VsHi  = PosW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic pix_en;

  pix_ce_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_ce_div (
    .CLK    (CLK),
    .RESET  (RESET),
    .pix_en (pix_en)
  );

  // Scan position and stage-0 state
  logic [PosW-1:0]  hpos_q, hpos_d;
  logic [PosW-1:0]  vpos_q, vpos_d;
  logic [PosW-1:0]  hcnt_q, hcnt_d;
  logic [VcntW-1:0] vrun_q, vrun_d;
  logic             de_q, de_d;
  logic             hs0_q, hs0_d;
  logic             vs0_q, vs0_d;
  logic             origin;
  logic             frame_start_q;

  // Output stage
  logic [1:0]       en_pipe_q;
  logic             cap;
  rgb444_t          rgb_q, rgb_d;
  logic             hsync_q;
  logic             vsync_q;

  // Next position and the stage-0 values it implies
  always_comb begin
    hpos_d = hpos_q + PosW'(1);
    vpos_d = vpos_q;
    if (hpos_q == HLast) begin
      hpos_d = '0;
      vpos_d = (vpos_q == VLast) ? '0 : vpos_q + PosW'(1);
    end

    origin = (hpos_d == '0) && (vpos_d == '0);
    de_d   = (hpos_d < HAct) && (vpos_d < VAct);
    hcnt_d = de_d ? hpos_d : '0;
    hs0_d  = !((hpos_d >= HsLo) && (hpos_d < HsHi));
    vs0_d  = !((vpos_d >= VsLo) && (vpos_d < VsHi));

    // Running linear index: bump only when leaving an active pixel
    vrun_d = vrun_q;
    if (origin) begin
      vrun_d = '0;
    end else if (de_q) begin
      vrun_d = vrun_q + VcntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hpos_q <= HLast;
      vpos_q <= VLast;
      hcnt_q <= '0;
      vrun_q <= '0;
      de_q   <= 1'b0;
      hs0_q  <= 1'b1;
      vs0_q  <= 1'b1;
    end else if (pix_en) begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      hcnt_q <= hcnt_d;
      vrun_q <= vrun_d;
      de_q   <= de_d;
      hs0_q  <= hs0_d;
      vs0_q  <= vs0_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_en && origin;
    end
  end

  // cap lands one CLK after the lookup has registered the new coordinates
  assign cap = en_pipe_q[1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      en_pipe_q <= '0;
    end else begin
      en_pipe_q <= {en_pipe_q[0], pix_en};
    end
  end

  always_comb begin
    rgb_d = '0;
    if (de_q) begin
      rgb_d = on ? FG_COLOR : BG_COLOR;
    end
  end

  // Stage-0 flags are still stable here since PIX_DIV >= 3
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (cap) begin
      rgb_q   <= rgb_d;
      hsync_q <= hs0_q;
      vsync_q <= vs0_q;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = de_q ? vrun_q : '0;
  assign de          = de_q;
  assign frame_start = frame_start_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed scoreboard bench for vga_scan_gen on a small 14x7 raster.
module tb_vga_scan_gen;

  localparam int HA = 8;
  localparam int HT = 14;
  localparam int VA = 4;
  localparam int VT = 7;
  localparam int PD = 4;
  localparam int FRAME_CLK = HT * VT * PD;

  logic        CLK;
  logic        RESET;
  logic        on;
  logic [13:0] hcnt;
  logic [23:0] vcnt;
  logic        de;
  logic        frame_start;
  logic        HSYNC;
  logic        VSYNC;
  logic [11:0] rgb;

  vga_scan_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .PIX_DIV  (4),
    .FG_COLOR (12'hFFF),
    .BG_COLOR (12'h000)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .on          (on),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .de          (de),
    .frame_start (frame_start),
    .HSYNC       (HSYNC),
    .VSYNC       (VSYNC),
    .rgb         (rgb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Bench model state
  int          cycle;
  int          mdiv;
  int          mh;
  int          mv;
  logic        exp_de;
  logic [13:0] exp_hcnt;
  logic [23:0] exp_vcnt;
  logic        exp_fs;
  logic [11:0] hold_rgb;
  logic        hold_hs;
  logic        hold_vs;
  int          last_fs;
  int          fs_seen;
  int          vmax;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cycle);
    end
  endtask

  task automatic model_reset();
    cycle    = 0;
    mdiv     = 0;
    mh       = HT - 1;
    mv       = VT - 1;
    exp_de   = 1'b0;
    exp_hcnt = '0;
    exp_vcnt = '0;
    exp_fs   = 1'b0;
    hold_rgb = 12'h000;
    hold_hs  = 1'b1;
    hold_vs  = 1'b1;
    last_fs  = -1;
    sb.delete();
  endtask

  // Advance one CLK, update the model, push/pop the scoreboard, compare everything.
  task automatic tick();
    logic        pix;
    logic [11:0] col;
    exp_t        e;
    pix = (mdiv == PD - 1);
    @(posedge CLK);
    #1;
    cycle++;
    mdiv   = pix ? 0 : mdiv + 1;
    exp_fs = 1'b0;
    if (pix) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      exp_de   = (mh < HA) && (mv < VA);
      exp_hcnt = exp_de ? 14'(mh) : 14'd0;
      exp_vcnt = exp_de ? 24'(mv * HA + mh) : 24'd0;
      exp_fs   = (mh == 0) && (mv == 0);
      on       = exp_hcnt[0];
      col      = exp_de ? (on ? 12'hFFF : 12'h000) : 12'h000;
      e.due    = cycle + 2;
      e.rgb    = col;
      e.hs     = !((mh >= 10) && (mh < 12));
      e.vs     = !(mv == 5);
      sb.push_back(e);
    end
    if (sb.size() > 0 && sb[0].due == cycle) begin
      e        = sb.pop_front();
      hold_rgb = e.rgb;
      hold_hs  = e.hs;
      hold_vs  = e.vs;
    end
    chk("hcnt", 32'(hcnt), 32'(exp_hcnt));
    chk("vcnt", 32'(vcnt), 32'(exp_vcnt));
    chk("de", 32'(de), 32'(exp_de));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    chk("rgb", 32'(rgb), 32'(hold_rgb));
    chk("HSYNC", 32'(HSYNC), 32'(hold_hs));
    chk("VSYNC", 32'(VSYNC), 32'(hold_vs));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", 32'(cycle - last_fs), 32'(FRAME_CLK));
      last_fs = cycle;
      fs_seen++;
    end
    if (vcnt > 24'(vmax)) vmax = int'(vcnt);
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    on    = 1'b0;
    model_reset();
    fs_seen = 0;
    vmax    = 0;

    // Reset state
    #1 RESET = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hsync", 32'(HSYNC), 32'h1);
    chk("rst_vsync", 32'(VSYNC), 32'h1);
    chk("rst_hcnt", 32'(hcnt), 32'h0);
    chk("rst_vcnt", 32'(vcnt), 32'h0);
    chk("rst_de", 32'(de), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);

    repeat (2) @(posedge CLK);
    #3 RESET = 1'b1;
    model_reset();

    // Two full frames plus a few pixels
    repeat (2 * FRAME_CLK + 16) tick();
    chk("fs_count", 32'(fs_seen), 32'd3);
    chk("vcnt_max", 32'(vmax), 32'd31);

    // Reset mid-frame at hpos 5, vpos 2
    n = 0;
    while (!(mh == 5 && mv == 2) && n < 2 * FRAME_CLK) begin
      tick();
      n++;
    end
    chk("reach_pos", 32'(n < 2 * FRAME_CLK), 32'd1);
    repeat (3) tick();
    chk("pre_rst_rgb", 32'(rgb), 32'hFFF);
    chk("pre_rst_hcnt", 32'(hcnt), 32'd5);
    #3 RESET = 1'b0;
    on = 1'b0;
    #1;
    chk("mid_rst_rgb", 32'(rgb), 32'h0);
    chk("mid_rst_hsync", 32'(HSYNC), 32'h1);
    chk("mid_rst_vsync", 32'(VSYNC), 32'h1);
    chk("mid_rst_hcnt", 32'(hcnt), 32'h0);
    chk("mid_rst_vcnt", 32'(vcnt), 32'h0);
    chk("mid_rst_de", 32'(de), 32'h0);
    #2 RESET = 1'b1;
    model_reset();

    repeat (PD) tick();
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk("restart_hcnt", 32'(hcnt), 32'd0);
    chk("restart_de", 32'(de), 32'd1);
    repeat (FRAME_CLK + 8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster scan generator for the grid-drawing datapath. It produces the active-area pixel coordinates that the cell-lookup block consumes: `hcnt` is the column within the line, and `vcnt` is the linear pixel index within the frame. It samples the returned `on` bit and drives registered RGB and sync outputs to the VGA connector, aligned to that lookup's one-cycle registered latency. It sits between the board clock and the display pins and owns all video timing.

## Interface
- `H_ACTIVE`, 480: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 48 / `H_BP`, 56: horizontal porch/sync widths, in pixels
- `V_ACTIVE`, 270: visible lines per frame
- `V_FP`, 3 / `V_SYNC`, 5 / `V_BP`, 22: vertical porch/sync widths, in lines
- `PIX_DIV`, 4: CLK cycles per pixel; legal range 3..16
- `FG_COLOR`, 12'hFFF: RGB444 colour for `on`=1
- `BG_COLOR`, 12'h000: RGB444 colour for `on`=0 inside the active area
- `CLK` in 1: single clock, rising edge
- `RESET` in 1: asynchronous assert, active-low; deassertion is synchronous to `CLK`
- `on` in 1: cell-lit bit from the lookup block, valid 1 CLK after `hcnt`/`vcnt` change
- `hcnt` out 14: active column, 0..H_ACTIVE-1; 0 outside the active area
- `vcnt` out 24: linear active pixel index, 0..H_ACTIVE*V_ACTIVE-1; 0 outside the active area
- `de` out 1: stage-0 active flag, aligned with `hcnt`/`vcnt`
- `frame_start` out 1: one-CLK pulse when position (0,0) is issued
- `HSYNC`, `VSYNC` out 1 each: active-low syncs, aligned with `rgb`
- `rgb` out 12: {R[3:0],G[3:0],B[3:0]}

## Operation
- The divider counts `div` from 0 to PIX_DIV-1 and wraps. `pix_en` is asserted when `div`==PIX_DIV-1.
- Position counters: `hpos` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. `vpos` runs 0..V_TOTAL-1 with the same construction.
- On `pix_en`, `hpos` increments. When `hpos` wraps to 0, `vpos` increments. When both wrap, the frame restarts.
- Stage 0, registered on `pix_en`:
  - `de` = (hpos<H_ACTIVE && vpos<V_ACTIVE), evaluated on the new position.
  - `hcnt` = hpos when `de`, else 0.
  - `vcnt` is a running counter, not a multiply. It is cleared when the new position is (0,0). Otherwise it increments by 1 on each `pix_en` whose previous position was active. It is forced to 0 on output while `de`=0.
- Stage 0 sync flags:
  - `hs0` = low while H_ACTIVE+H_FP ≤ hpos < H_ACTIVE+H_FP+H_SYNC.
  - `vs0` = low while V_ACTIVE+V_FP ≤ vpos < V_ACTIVE+V_FP+V_SYNC.
- Output stage: `cap` is `pix_en` delayed by 2 CLK. On `cap`:
  - `rgb` <= de_d ? (on ? FG_COLOR : BG_COLOR) : 12'h000
  - `HSYNC` <= hs0_d
  - `VSYNC` <= vs0_d
  - de_d, hs0_d and vs0_d are the stage-0 values, held until `cap`.
- `frame_start` = 1 for exactly the CLK following the `pix_en` that lands on (0,0).
- Reset values:
  - `div`=0; `hpos`=H_TOTAL-1; `vpos`=V_TOTAL-1, so the first `pix_en` lands on (0,0).
  - `hcnt`=0, `vcnt`=0, `de`=0, `frame_start`=0.
  - `HSYNC`=1, `VSYNC`=1, `rgb`=0, delay pipes cleared.
- Reset asserted mid-frame: all state returns to reset values immediately, with no partial-line completion. After deassertion the scan restarts at (0,0) with a fresh `frame_start`.

## Timing
- Latency: position update on `pix_en` edge N, then `on` valid at N+1, then `rgb`/syncs update at N+2. Outputs hold for PIX_DIV CLK.
- PIX_DIV ≥ 3 guarantees `hcnt`/`vcnt` are stable through the lookup's registered sample.
- `vcnt` wraps only via the (0,0) clear; it never exceeds H_ACTIVE*V_ACTIVE-1 = 129599 at defaults, which fits in 24 bits.
- `hcnt` = 479 is followed by 0 on the first blanking pixel.
- The `vcnt` increment resumes on the next line's first active pixel.
- No handshake and no backpressure. `on` is sampled unconditionally at `cap`.

## Structure
- `vga_scan_pkg`: H_TOTAL/V_TOTAL derivation functions, sync-window boundary constants, colour width (12) and the RGB444 field positions.
- One sub-module: `pix_ce_div` (PIX_DIV counter and `pix_en` generation). The rest is inline counters and delay registers.

## Test plan
- Small config, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, PIX_DIV=4, one full frame:
  - `hcnt` sequence is 0..7 then 0 for 6 pixels.
  - `vcnt` runs 0..31 with no gaps.
  - `frame_start` pulses once per 14*7 `pix_en`.
- Same config, `on` tied to `hcnt`[0]: `rgb` alternates 000/FFF in the active area, is 000 in blanking, and changes exactly 2 CLK after each `pix_en`.
- Sync windows:
  - `HSYNC` is low for exactly 2 pixels starting at hpos 10.
  - `VSYNC` is low for exactly 1 line starting at vpos 5.
  - Both edges are co-aligned with `rgb` updates.
- Reset pulse at hpos 5, vpos 2:
  - Immediately: `rgb`=0, `HSYNC`=`VSYNC`=1, `hcnt`=`vcnt`=0.
  - After release, the first `pix_en` gives (0,0) and `frame_start`=1.
- Defaults for 2 frames: last active `vcnt`=129599, then 0 at the next frame start; frame period = 600*300*4 CLK.
